// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader:
// FSM states, stream framing constants and checksum width.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    RUN     = 3'd6,
    ERROR   = 3'd7
  } state_t;

  // Stream framing: big-endian 16-bit length, then hi/lo byte pairs, then one checksum byte.
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned CSUM_BYTES     = 1;
  localparam int unsigned POS_LEN_HI     = 0;
  localparam int unsigned POS_LEN_LO     = 1;
  localparam int unsigned POS_DATA       = 2;

  localparam int unsigned CSUM_W = 8;

  function automatic logic is_loading(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and releases the core on success.
// One byte per cycle max; write strobe lands the cycle after each low byte; byte_ready low outside loading states.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  state_t              r_state;
  logic                r_byte_ready;
  logic                r_we;
  logic [15:0]         r_addr;
  logic [15:0]         r_wdata;
  logic                r_core_rst_n;
  logic                r_done;
  logic                r_error;
  logic [15:0]         r_index;
  logic [15:0]         r_len;
  logic [7:0]          r_hi;
  logic [CSUM_W-1:0]   r_csum;

  logic                w_xfer;
  logic [15:0]         w_len;
  logic                w_len_bad;
  logic [15:0]         w_index_nxt;

  assign w_xfer      = byte_valid & r_byte_ready;
  assign w_len       = {r_len[15:8], byte_data};
  assign w_len_bad   = (w_len == 16'd0) || ({16'd0, w_len} > 32'(MEM_DEPTH));
  assign w_index_nxt = r_index + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 16'd0;
      r_wdata      <= 16'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_index      <= 16'd0;
      r_len        <= 16'd0;
      r_hi         <= 8'd0;
      r_csum       <= '0;
    end else begin
      r_we <= 1'b0;
      // A start pulse restarts from any state and drops any byte offered in the same cycle.
      if (start) begin
        r_state      <= LEN_HI;
        r_byte_ready <= 1'b1;
        r_core_rst_n <= 1'b0;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_index      <= 16'd0;
        r_csum       <= '0;
      end else if (w_xfer) begin
        case (r_state)
          LEN_HI: begin
            r_len[15:8] <= byte_data;
            r_state     <= LEN_LO;
          end
          LEN_LO: begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state      <= ERROR;
              r_error      <= 1'b1;
              r_byte_ready <= 1'b0;
            end else begin
              r_state <= DATA_HI;
            end
          end
          DATA_HI: begin
            r_hi    <= byte_data;
            r_csum  <= r_csum ^ byte_data;
            r_state <= DATA_LO;
          end
          DATA_LO: begin
            r_we    <= 1'b1;
            r_addr  <= BASE_ADDR + r_index;
            r_wdata <= {r_hi, byte_data};
            r_index <= w_index_nxt;
            r_csum  <= r_csum ^ byte_data;
            r_state <= (w_index_nxt == r_len) ? CHECK : DATA_HI;
          end
          CHECK: begin
            r_byte_ready <= 1'b0;
            if (r_csum == byte_data) begin
              r_state      <= RUN;
              r_done       <= 1'b1;
              r_core_rst_n <= 1'b1;
            end else begin
              r_state      <= ERROR;
              r_error      <= 1'b1;
              r_core_rst_n <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = r_byte_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good/bad loads, backpressure, restart and mid-load reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wq[$];
  logic [7:0]  good_s [7] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};

  imem_loader #(.MEM_DEPTH(256), .BASE_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Each write strobe is one cycle wide, so one negedge sample per pulse.
  always @(negedge clk) if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    while (byte_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (byte_ready !== 1'b1) begin
      chk("ready_timeout", 64'(byte_ready), 64'd1);
      byte_valid = 1'b0;
      return;
    end
    tick();
    byte_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_good(input bit gap);
    for (int i = 0; i < 7; i++) send_byte(good_s[i], gap);
  endtask

  task automatic check_good(input string p);
    chk({p, "_done"},   64'(done), 64'd1);
    chk({p, "_corern"}, 64'(core_rst_n), 64'd1);
    chk({p, "_error"},  64'(error), 64'd0);
    chk({p, "_nwr"},    64'(wq.size()), 64'd2);
    chk({p, "_wr0"},    64'(wq.size() > 0 ? wq[0] : 32'hDEAD_BEEF), 64'h0000_1234);
    chk({p, "_wr1"},    64'(wq.size() > 1 ? wq[1] : 32'hDEAD_BEEF), 64'h0001_ABCD);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_outs", {byte_ready, imem_we, core_rst_n, done, error, imem_addr, imem_wdata}, 64'd0);
    chk("rst_state", 64'(dut.r_state), 64'(IDLE));
    rst = 1'b1;
    tick();

    // Bytes offered in IDLE are ignored
    byte_valid = 1'b1; byte_data = 8'h55;
    tick(); tick();
    byte_valid = 1'b0;
    chk("idle_ignore", {64'(dut.r_state), 64'(byte_ready)} , {64'(IDLE), 64'd0});

    // Good load
    pulse_start();
    chk("start_ready", {byte_ready, core_rst_n}, 64'b10);
    wq.delete();
    send_good(1'b0);
    check_good("good");
    chk("hold_after", {imem_we, imem_addr, imem_wdata}, {1'b0, 16'h0001, 16'hABCD});
    chk("run_state", 64'(dut.r_state), 64'(RUN));

    // Bad checksum, started from RUN
    pulse_start();
    chk("restart_corern", {core_rst_n, done}, 64'd0);
    wq.delete();
    for (int i = 0; i < 6; i++) send_byte(good_s[i], 1'b0);
    send_byte(8'h41, 1'b0);
    chk("badck_flags", {error, core_rst_n, done, byte_ready}, 64'b1000);
    chk("badck_nwr", 64'(wq.size()), 64'd2);

    // Bad length: zero
    pulse_start();
    wq.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len0_state", 64'(dut.r_state), 64'(ERROR));
    chk("len0_flags", {error, byte_ready, done}, 64'b100);
    byte_valid = 1'b1; byte_data = 8'h12;
    tick(); tick(); tick();
    byte_valid = 1'b0;
    chk("len0_ignore", {64'(dut.r_state), 64'(wq.size())}, {64'(ERROR), 64'd0});

    // Bad length: 257 > MEM_DEPTH
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("len257_state", 64'(dut.r_state), 64'(ERROR));
    chk("len257_flags", {error, byte_ready, imem_we}, 64'b100);

    // Boundary: 256 == MEM_DEPTH is accepted
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len256_state", {64'(dut.r_state), 64'(error)}, {64'(DATA_HI), 64'd0});

    // Backpressure: valid toggles 1/0
    pulse_start();
    wq.delete();
    send_good(1'b1);
    check_good("bp");

    // Interrupted load; the restarting start coincides with a ready byte, which is dropped
    pulse_start();
    wq.delete();
    for (int i = 0; i < 5; i++) send_byte(good_s[i], 1'b0);
    chk("intr_state", 64'(dut.r_state), 64'(DATA_LO));
    byte_valid = 1'b1; byte_data = 8'hCD; start = 1'b1;
    tick();
    start = 1'b0; byte_valid = 1'b0;
    tick();
    chk("intr_restart", {64'(dut.r_state), 64'(wq.size())}, {64'(LEN_HI), 64'd1});
    wq.delete();
    send_good(1'b0);
    check_good("intr");

    // Reset during DATA_LO
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(good_s[i], 1'b0);
    chk("mid_state", 64'(dut.r_state), 64'(DATA_LO));
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {byte_ready, imem_we, core_rst_n, done, error, imem_addr, imem_wdata}, 64'd0);
    tick(); tick();
    chk("mid_rst_state", {64'(dut.r_state), 64'(dut.r_index)}, {64'(IDLE), 64'd0});
    rst = 1'b1;
    tick();
    pulse_start();
    wq.delete();
    send_good(1'b0);
    check_good("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
